// File: rtl/contador_programa16_pkg.sv
// contador_programa16_pkg
//   Shared definitions for the program-counter sequencer:
//   - default reset address and address width
//   - command encoding, in priority order
//   - decodifica_cmd: turns the raw strobes into the single command executed this cycle
package contador_programa16_pkg;

   localparam int          LARGURA_PADRAO        = 16;
   localparam logic [15:0] ENDERECO_RESET_PADRAO = 16'h0000;

   // Listed from highest to lowest priority.
   typedef enum logic [2:0] {
      CMD_CLR  = 3'd0,
      CMD_RET  = 3'd1,
      CMD_CALL = 3'd2,
      CMD_LOAD = 3'd3,
      CMD_INC  = 3'd4,
      CMD_HOLD = 3'd5
   } cmd_t;

   // Exactly one command wins. Lower-priority strobes are dropped, not queued.
   function automatic cmd_t decodifica_cmd(input logic clr,
                                           input logic retorno,
                                           input logic chamada,
                                           input logic carga,
                                           input logic inc);
      if (clr)          return CMD_CLR;
      else if (retorno) return CMD_RET;
      else if (chamada) return CMD_CALL;
      else if (carga)   return CMD_LOAD;
      else if (inc)     return CMD_INC;
      else              return CMD_HOLD;
   endfunction

endpackage

// File: rtl/contador_programa16_inc16.sv
// inc16
//   16-bit incrementer: saida = entrada + 1 + carry_in (modulo 2^16).
//   Ports:
//     entrada  in  16  value to increment
//     carry_in in  1   extra increment (tied to 0 by the sequencer)
//     saida    out 16  incremented value; wraps FFFF -> 0000 silently
module inc16
   import contador_programa16_pkg::*;
(
   input  logic [15:0] entrada,
   input  logic        carry_in,
   output logic [15:0] saida
);

   assign saida = entrada + 16'd1 + {15'd0, carry_in};

endmodule

// File: rtl/contador_programa16.sv
// contador_programa16
//   Program-counter sequencer with a small return-address stack.
//   Each cycle exactly one action is taken, in priority order:
//   clr > retorno > chamada > carga > inc > hold.
//   Ports:
//     clk          in   1   rising-edge clock
//     rst_n        in   1   asynchronous active-low reset
//     clr          in   1   synchronous clear: saida, stack pointer and erro
//     retorno      in   1   pop return address into saida
//     chamada      in   1   push saida+1, jump to entrada
//     carga        in   1   load entrada into saida
//     inc          in   1   saida <= saida+1
//     entrada      in   16  jump/load target
//     saida        out  16  current program counter (registered)
//     pilha_vazia  out  1   stack empty
//     pilha_cheia  out  1   stack full
//     erro         out  1   sticky overflow/underflow flag
module contador_programa16
   import contador_programa16_pkg::*;
#(
   parameter int          LARGURA        = LARGURA_PADRAO,
   parameter int          PROF_PILHA     = 4,
   parameter logic [15:0] ENDERECO_RESET = ENDERECO_RESET_PADRAO
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               retorno,
   input  logic               chamada,
   input  logic               carga,
   input  logic               inc,
   input  logic [LARGURA-1:0] entrada,
   output logic [LARGURA-1:0] saida,
   output logic               pilha_vazia,
   output logic               pilha_cheia,
   output logic               erro
);

   localparam int SP_W  = $clog2(PROF_PILHA + 1);
   // Index width for the stack array itself; at least one bit.
   localparam int IDX_W = (PROF_PILHA > 1) ? $clog2(PROF_PILHA) : 1;

   logic [LARGURA-1:0] pilha [PROF_PILHA];
   logic [SP_W-1:0]    sp;

   logic [LARGURA-1:0] saida_mais1;
   logic [LARGURA-1:0] saida_prox;
   logic [SP_W-1:0]    sp_prox;
   logic               erro_prox;
   logic               empilha;
   logic [IDX_W-1:0]   idx_push;
   logic [IDX_W-1:0]   idx_pop;
   logic               vazia;
   logic               cheia;
   cmd_t               cmd;

   // One incrementer serves both the inc path and the pushed return address.
   inc16 u_inc16 (
      .entrada  (saida),
      .carry_in (1'b0),
      .saida    (saida_mais1)
   );

   assign vazia    = (sp == '0);
   assign cheia    = (sp == SP_W'(PROF_PILHA));
   assign idx_push = IDX_W'(sp);
   assign idx_pop  = IDX_W'(sp - SP_W'(1));

   assign cmd = decodifica_cmd(clr, retorno, chamada, carga, inc);

   always_comb begin
      saida_prox = saida;
      sp_prox    = sp;
      erro_prox  = erro;
      empilha    = 1'b0;
      case (cmd)
         CMD_CLR: begin
            saida_prox = ENDERECO_RESET;
            sp_prox    = '0;
            erro_prox  = 1'b0;
         end
         CMD_RET: begin
            if (vazia) begin
               erro_prox = 1'b1;
            end else begin
               saida_prox = pilha[idx_pop];
               sp_prox    = sp - SP_W'(1);
            end
         end
         CMD_CALL: begin
            // A call on a full stack is refused entirely: no push, no jump.
            if (cheia) begin
               erro_prox = 1'b1;
            end else begin
               empilha    = 1'b1;
               saida_prox = entrada;
               sp_prox    = sp + SP_W'(1);
            end
         end
         CMD_LOAD: saida_prox = entrada;
         CMD_INC:  saida_prox = saida_mais1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         saida <= ENDERECO_RESET;
         sp    <= '0;
         erro  <= 1'b0;
      end else begin
         saida <= saida_prox;
         sp    <= sp_prox;
         erro  <= erro_prox;
      end
   end

   // Stack contents need no reset: sp=0 makes every entry unreachable.
   always_ff @(posedge clk) begin
      if (empilha) begin
         pilha[idx_push] <= saida_mais1;
      end
   end

   assign pilha_vazia = vazia;
   assign pilha_cheia = cheia;

endmodule

// File: tb/tb_contador_programa16.sv
module tb_contador_programa16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr, retorno, chamada, carga, inc;
   logic [15:0] entrada;
   logic [15:0] saida;
   logic        pilha_vazia, pilha_cheia, erro;

   int total = 0;
   int bad   = 0;

   // Expected {saida, pilha_vazia, pilha_cheia, erro}
   logic [18:0] exp_q[$];

   typedef struct {
      logic        c, r, ch, ca, i;
      logic [15:0] ent;
      logic [15:0] s;
      logic        v, f, e;
   } vec_t;

   vec_t tab[29];

   // Reference model state for the random phase
   logic [15:0] m_s;
   logic        m_e;
   logic [15:0] m_stk[$];

   contador_programa16 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .retorno     (retorno),
      .chamada     (chamada),
      .carga       (carga),
      .inc         (inc),
      .entrada     (entrada),
      .saida       (saida),
      .pilha_vazia (pilha_vazia),
      .pilha_cheia (pilha_cheia),
      .erro        (erro)
   );

   always #5 clk = ~clk;

   function automatic logic [18:0] pack_out(input logic [15:0] s, input logic v, input logic f,
                                             input logic e);
      return {s, v, f, e};
   endfunction

   task automatic chk(input string nm, input logic [18:0] got, input logic [18:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got saida=%h vazia=%b cheia=%b erro=%b, expected saida=%h vazia=%b cheia=%b erro=%b",
                  nm, got[18:3], got[2], got[1], got[0], want[18:3], want[2], want[1], want[0]);
      end
   endtask

   // Drive one cycle of strobes, queue the expected result, compare after the edge.
   task automatic step(input logic c, input logic r, input logic ch, input logic ca, input logic i,
                       input logic [15:0] ent, input logic [18:0] want, input string nm);
      logic [18:0] e;
      clr = c; retorno = r; chamada = ch; carga = ca; inc = i; entrada = ent;
      exp_q.push_back(want);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         e = exp_q.pop_front();
         chk(nm, pack_out(saida, pilha_vazia, pilha_cheia, erro), e);
      end
   endtask

   task automatic idle();
      clr = 0; retorno = 0; chamada = 0; carga = 0; inc = 0; entrada = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();

      //            c  r  ch ca i  entrada   saida     v  f  e
      tab[0]  = '{0, 0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0};
      tab[1]  = '{0, 0, 0, 0, 1, 16'h0000, 16'h0002, 1, 0, 0};
      tab[2]  = '{0, 0, 0, 0, 1, 16'h0000, 16'h0003, 1, 0, 0};
      tab[3]  = '{0, 0, 0, 1, 0, 16'hFFFE, 16'hFFFE, 1, 0, 0};
      tab[4]  = '{0, 0, 0, 0, 1, 16'h0000, 16'hFFFF, 1, 0, 0};
      tab[5]  = '{0, 0, 0, 0, 1, 16'h0000, 16'h0000, 1, 0, 0};
      tab[6]  = '{0, 0, 0, 1, 0, 16'h0010, 16'h0010, 1, 0, 0};
      tab[7]  = '{0, 0, 1, 0, 0, 16'h0100, 16'h0100, 0, 0, 0};
      tab[8]  = '{0, 0, 0, 0, 1, 16'h0000, 16'h0101, 0, 0, 0};
      tab[9]  = '{0, 1, 0, 0, 0, 16'h0000, 16'h0011, 1, 0, 0};
      tab[10] = '{0, 1, 0, 0, 0, 16'h0000, 16'h0011, 1, 0, 1};
      tab[11] = '{0, 0, 0, 0, 1, 16'h0000, 16'h0012, 1, 0, 1};
      tab[12] = '{1, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0};
      tab[13] = '{0, 0, 1, 0, 0, 16'h1000, 16'h1000, 0, 0, 0};
      tab[14] = '{0, 0, 1, 0, 0, 16'h2000, 16'h2000, 0, 0, 0};
      tab[15] = '{0, 0, 1, 0, 0, 16'h3000, 16'h3000, 0, 0, 0};
      tab[16] = '{0, 0, 1, 0, 0, 16'h4000, 16'h4000, 0, 1, 0};
      tab[17] = '{0, 0, 1, 0, 0, 16'h5000, 16'h4000, 0, 1, 1};
      tab[18] = '{0, 1, 0, 0, 0, 16'h0000, 16'h3001, 0, 0, 1};
      tab[19] = '{0, 1, 0, 0, 0, 16'h0000, 16'h2001, 0, 0, 1};
      tab[20] = '{0, 1, 0, 0, 0, 16'h0000, 16'h1001, 0, 0, 1};
      tab[21] = '{0, 1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 1};
      tab[22] = '{1, 0, 1, 0, 1, 16'h7777, 16'h0000, 1, 0, 0};
      tab[23] = '{0, 0, 0, 1, 1, 16'h0ABC, 16'h0ABC, 1, 0, 0};
      tab[24] = '{0, 1, 1, 1, 1, 16'h1234, 16'h0ABC, 1, 0, 1};
      tab[25] = '{1, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0};
      tab[26] = '{0, 0, 1, 1, 0, 16'h0200, 16'h0200, 0, 0, 0};
      tab[27] = '{0, 1, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0};
      tab[28] = '{0, 0, 0, 0, 0, 16'hBEEF, 16'h0001, 1, 0, 0};

      #12;
      chk("reset", pack_out(saida, pilha_vazia, pilha_cheia, erro), pack_out(16'h0000, 1, 0, 0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_after_reset", pack_out(saida, pilha_vazia, pilha_cheia, erro),
          pack_out(16'h0000, 1, 0, 0));

      for (int k = 0; k < 29; k++) begin
         step(tab[k].c, tab[k].r, tab[k].ch, tab[k].ca, tab[k].i, tab[k].ent,
              pack_out(tab[k].s, tab[k].v, tab[k].f, tab[k].e), $sformatf("vec%0d", k));
      end

      // Asynchronous reset in mid-cycle with two entries on the stack.
      step(0, 0, 1, 0, 0, 16'h0300, pack_out(16'h0300, 0, 0, 0), "rst_call1");
      step(0, 0, 1, 0, 0, 16'h0400, pack_out(16'h0400, 0, 0, 0), "rst_call2");
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", pack_out(saida, pilha_vazia, pilha_cheia, erro), pack_out(16'h0000, 1, 0, 0));
      #1;
      rst_n = 1'b1;
      step(0, 0, 0, 0, 1, 16'h0000, pack_out(16'h0001, 1, 0, 0), "post_rst_inc");
      step(0, 1, 0, 0, 0, 16'h0000, pack_out(16'h0001, 1, 0, 1), "post_rst_pop_empty");
      step(1, 0, 0, 0, 0, 16'h0000, pack_out(16'h0000, 1, 0, 0), "post_rst_clr");

      // Random phase against a behavioural model.
      m_s = 16'h0000;
      m_e = 1'b0;
      m_stk.delete();
      for (int n = 0; n < 300; n++) begin
         logic c, r, ch, ca, i;
         logic [15:0] ent;
         c   = ($urandom_range(0, 24) == 0);
         r   = ($urandom_range(0, 3) == 0);
         ch  = ($urandom_range(0, 2) == 0);
         ca  = ($urandom_range(0, 4) == 0);
         i   = ($urandom_range(0, 1) == 0);
         ent = 16'($urandom_range(0, 65535));
         if (c) begin
            m_s = 16'h0000;
            m_stk.delete();
            m_e = 1'b0;
         end else if (r) begin
            if (m_stk.size() > 0) m_s = m_stk.pop_back();
            else                  m_e = 1'b1;
         end else if (ch) begin
            if (m_stk.size() < 4) begin
               m_stk.push_back(m_s + 16'd1);
               m_s = ent;
            end else begin
               m_e = 1'b1;
            end
         end else if (ca) begin
            m_s = ent;
         end else if (i) begin
            m_s = m_s + 16'd1;
         end
         step(c, r, ch, ca, i, ent,
              pack_out(m_s, m_stk.size() == 0, m_stk.size() == 4, m_e), $sformatf("rand%0d", n));
      end

      idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
